// File: rtl/demux4_pkg.sv
// rtl/demux4_pkg.sv - shared types and constants for the demux4_stream block
// Contents:
//   NUM_CH     number of output channels
//   chan_t     channel index type
//   RR_RESET   round-robin pointer reset value
//   next_chan  round-robin successor (3 wraps to 0)
package demux4_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] chan_t;

    localparam chan_t RR_RESET = 2'd0;

    function automatic chan_t next_chan(input chan_t c);
        return c + 2'd1;
    endfunction

endpackage

// File: rtl/demux4_slot.sv
// rtl/demux4_slot.sv - single-entry output register with valid flag and deliver counter
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   load       write load_data into the slot this cycle
//   load_data  beat to store
//   ready      consumer accepts the held beat
//   valid      slot holds a beat
//   data       held beat (retains last value while empty)
//   cnt        number of delivered beats, wraps
module demux4_slot #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt
);

    logic deliver;

    assign deliver = valid & ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            cnt   <= '0;
        end else begin
            // A load in the same cycle as a deliver refills the slot, so
            // valid stays high and the consumer sees no bubble.
            if (load) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (deliver) begin
                valid <= 1'b0;
            end
            if (deliver) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/demux4_stream.sv
// rtl/demux4_stream.sv - one-to-four stream demultiplexer with per-channel output slots
// Optional feature: define DEMUX4_STREAM_RR_EN for round-robin routing (sel ignored).
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    inbound beat
//   in_valid   inbound beat present
//   in_ready   inbound beat accepted this cycle
//   sel        destination channel (explicit routing)
//   out_data   channel k at [k*WIDTH +: WIDTH]
//   out_valid  per-channel beat held
//   out_ready  per-channel consumer accepts
//   xfer_cnt   channel k delivered-beat count at [k*CNT_W +: CNT_W]
module demux4_stream
    import demux4_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              sel,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*CNT_W-1:0] xfer_cnt
);

    chan_t             dest;
    logic              accept;
    logic [NUM_CH-1:0] load;

`ifdef DEMUX4_STREAM_RR_EN
    chan_t rr_ptr;
    logic  unused_sel;

    assign unused_sel = ^sel;
    assign dest       = rr_ptr;

    // The pointer moves only on accept, so a blocked channel stalls the
    // input instead of being skipped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= RR_RESET;
        end else if (accept) begin
            rr_ptr <= next_chan(rr_ptr);
        end
    end
`else
    assign dest = sel;
`endif

    // Ready when the destination slot is empty, or when it is full but its
    // consumer takes the held beat in this same cycle (pass-through refill).
    assign in_ready = ~rst & (~out_valid[dest] | out_ready[dest]);
    assign accept   = in_valid & in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            load[k] = accept && (dest == chan_t'(k));
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux4_slot #(
            .WIDTH(WIDTH),
            .CNT_W(CNT_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[k]),
            .load_data(in_data),
            .ready    (out_ready[k]),
            .valid    (out_valid[k]),
            .data     (out_data[k*WIDTH +: WIDTH]),
            .cnt      (xfer_cnt[k*CNT_W +: CNT_W])
        );
    end

endmodule
